iir_biquad_seq: RTL and testbench



---
 rtl/iir_pkg.sv | 21 ++
 rtl/iir_coef_rf.sv | 70 +++++++
 rtl/iir_biquad_seq.sv | 178 +++++++++++++++++
 tb/tb_iir_biquad_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and constants for the time-multiplexed biquad IIR filter.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    localparam int NUM_TAPS = 5;

    // Coefficients restored by reset, indexed by tap: b0, b1, b2, a1, a2.
    localparam int RST_COEF [NUM_TAPS] = '{1, 1, 1, 2, 3};

endpackage

// File: rtl/iir_coef_rf.sv
// Five-entry coefficient register file: writes accepted only when allowed and in range,
// rejected writes raise a one-cycle error pulse; read is asynchronous by tap index.
module iir_coef_rf
    import iir_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [2:0]           addr,
    input  logic signed [CW-1:0] wdata,
    input  logic                 wr_allow,
    input  logic [2:0]           rd_tap,
    output logic signed [CW-1:0] rd_data,
    output logic                 err
);

    logic signed [CW-1:0] coef_q [NUM_TAPS];
    logic signed [CW-1:0] coef_d [NUM_TAPS];
    logic                 err_q;
    logic                 err_d;
    logic                 wr_ok_s;

    // Write acceptance and next coefficient contents
    always_comb begin
        wr_ok_s = we & wr_allow & (addr <= TAP_A2);
        coef_d  = coef_q;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (wr_ok_s && (addr == 3'(i))) begin
                coef_d[i] = wdata;
            end else begin
                coef_d[i] = coef_q[i];
            end
        end
        if (we && !wr_ok_s) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
    end

    // Coefficient and error-pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef_q[i] <= CW'(RST_COEF[i]);
            end
            err_q <= 1'b0;
        end else begin
            coef_q <= coef_d;
            err_q  <= err_d;
        end
    end

    // Tap-indexed read; out-of-range taps read as zero
    always_comb begin
        case (rd_tap)
            TAP_B0:  rd_data = coef_q[0];
            TAP_B1:  rd_data = coef_q[1];
            TAP_B2:  rd_data = coef_q[2];
            TAP_A1:  rd_data = coef_q[3];
            TAP_A2:  rd_data = coef_q[4];
            default: rd_data = '0;
        endcase
    end

    assign err = err_q;

endmodule

// File: rtl/iir_biquad_seq.sv
// Biquad IIR filter with one shared multiplier sequenced over five taps.
// Define IIR_SAT_EN to saturate the output to OW bits instead of wrapping.
module iir_biquad_seq
    import iir_pkg::*;
#(
    parameter int DW   = 4,
    parameter int CW   = 4,
    parameter int OW   = 12,
    parameter int FRAC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    input  logic                 coef_we,
    input  logic [2:0]           coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    output logic                 coef_err,
    output logic                 out_valid,
    output logic signed [OW-1:0] y
);

    localparam int AW = OW + CW + 3;

    state_e               state_q, state_d;
    logic [2:0]           tap_q, tap_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [OW-1:0] y1_q, y1_d, y2_q, y2_d, y_q, y_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic signed [CW-1:0]    coef_s;
    logic signed [OW-1:0]    op_s;
    logic signed [OW+CW-1:0] prod_s;
    logic signed [AW-1:0]    prod_ext_s;
    logic signed [OW-1:0]    yq_s;

    iir_coef_rf #(.CW(CW)) u_coef_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (coef_we),
        .addr     (coef_addr),
        .wdata    (coef_wdata),
        .wr_allow (state_q == IDLE),
        .rd_tap   (tap_q),
        .rd_data  (coef_s),
        .err      (coef_err)
    );

    // Operand selection for the current tap; samples are sign-extended to OW
    always_comb begin
        case (tap_q)
            TAP_B0:  op_s = {{(OW-DW){x0_q[DW-1]}}, x0_q};
            TAP_B1:  op_s = {{(OW-DW){x1_q[DW-1]}}, x1_q};
            TAP_B2:  op_s = {{(OW-DW){x2_q[DW-1]}}, x2_q};
            TAP_A1:  op_s = y1_q;
            TAP_A2:  op_s = y2_q;
            default: op_s = '0;
        endcase
    end

    assign prod_s     = {{CW{op_s[OW-1]}}, op_s} * {{OW{coef_s[CW-1]}}, coef_s};
    assign prod_ext_s = {{3{prod_s[OW+CW-1]}}, prod_s};

`ifdef IIR_SAT_EN
    logic signed [AW-1:0] sh_s;

    // Clamp the scaled accumulator to the signed OW range
    always_comb begin
        sh_s = acc_q >>> FRAC;
        if ((&sh_s[AW-1:OW-1]) || (~|sh_s[AW-1:OW-1])) begin
            yq_s = sh_s[OW-1:0];
        end else if (sh_s[AW-1]) begin
            yq_s = {1'b1, {(OW-1){1'b0}}};
        end else begin
            yq_s = {1'b0, {(OW-1){1'b1}}};
        end
    end
`else
    assign yq_s = OW'(acc_q >>> FRAC);
`endif

    // Sequencer next-state, MAC datapath and delay-line update; clr overrides everything
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            tap_d   = 3'd0;
            acc_d   = '0;
            x1_d    = '0;
            x2_d    = '0;
            y1_d    = '0;
            y2_d    = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x0_d    = x;
                        acc_d   = '0;
                        tap_d   = 3'd0;
                        state_d = MAC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MAC: begin
                    acc_d = acc_q + prod_ext_s;
                    if (tap_q == TAP_A2) begin
                        tap_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        tap_d   = tap_q + 3'd1;
                    end
                end
                DONE: begin
                    y_d         = yq_s;
                    out_valid_d = 1'b1;
                    x2_d        = x1_q;
                    x1_d        = x0_q;
                    y2_d        = y1_q;
                    y1_d        = yq_s;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        in_ready_d = (state_d == IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tap_q       <= 3'd0;
            acc_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scoreboard bench for iir_biquad_seq: the driver queues hand-computed outputs,
// a negedge monitor pops and compares them on every out_valid.
module tb_iir_biquad_seq;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [3:0] x = 4'sd0;
    logic              coef_we = 1'b0;
    logic [2:0]        coef_addr = 3'd0;
    logic signed [3:0] coef_wdata = 4'sd0;
    logic              coef_err;
    logic              out_valid;
    logic signed [11:0] y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int abort_cnt = 0;
    int seen_abort = 0;
    int err_pulses = 0;
    int outs = 0;
    int busy = 0;
    bit trk = 1'b0;
    int exp_q[$];
    int acc_t[$];

`ifdef IIR_SAT_EN
    localparam int Y7 = 2047;
`else
    localparam int Y7 = -1727;
`endif

    iir_biquad_seq dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .out_valid  (out_valid),
        .y          (y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: output scoreboard, accept-to-output latency, in_ready busy window
    always @(negedge clk) begin
        if (seen_abort != abort_cnt) begin
            acc_t.delete();
            trk = 1'b0;
            seen_abort = abort_cnt;
        end
        if (coef_err) err_pulses++;
        if (out_valid) begin
            outs++;
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else chk("y", int'(y), exp_q.pop_front());
            if (acc_t.size() == 0) chk("latency_no_accept", 1, 0);
            else chk("latency", cyc - acc_t.pop_front(), 7);
        end
        if (trk) begin
            if (!in_ready) busy++;
            else begin
                chk("in_ready_low_cycles", busy, 6);
                trk = 1'b0;
            end
        end
        if (rst && in_valid && in_ready && !clr) begin
            acc_t.push_back(cyc);
            trk = 1'b1;
            busy = 0;
        end
    end

    // All tasks start and end at posedge + 1
    task automatic send(input logic signed [3:0] xv, input int expv, input bit push, input bit keep);
        int n = 0;
        in_valid = 1'b1;
        x = xv;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready_timeout", int'(in_ready), 1);
        if (push) exp_q.push_back(expv);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic signed [3:0] d, input int exp_err);
        coef_we = 1'b1;
        coef_addr = a;
        coef_wdata = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        chk("coef_err", int'(coef_err), exp_err);
        @(posedge clk); #1;
        chk("coef_err_end", int'(coef_err), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        chk("y_after_clr", int'(y), 0);
    endtask

    task automatic impulse3();
        send(4'sd1, 1, 1'b1, 1'b0);
        send(4'sd0, 3, 1'b1, 1'b0);
        send(4'sd0, 10, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        int imp [8];
        imp = '{1, 3, 10, 29, 88, 263, 790, Y7};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_y", int'(y), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_coef_err", int'(coef_err), 0);
        chk("reset_in_ready", int'(in_ready), 1);

        // Impulse with reset coefficients, including the overflowing 8th output
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 4'sd1 : 4'sd0, imp[i], 1'b1, 1'b0);
        end
        drain();
        pulse_clr();

        // b0 = -2 from a cleared state
        wr(3'd0, 4'sb1110, 0);
        send(4'sd3, -6, 1'b1, 1'b0);
        drain();
        wr(3'd0, 4'sd1, 0);
        pulse_clr();

        // Rejected writes: one during MAC, one to an invalid address
        send(4'sd3, 3, 1'b1, 1'b0);
        wr(3'd0, 4'sd5, 1);
        drain();
        wr(3'd6, 4'sd5, 1);
        send(4'sd0, 9, 1'b1, 1'b0);
        send(4'sd1, 31, 1'b1, 1'b0);
        drain();
        pulse_clr();

        // in_valid held high with x = 1
        send(4'sd1, 1, 1'b1, 1'b1);
        send(4'sd1, 4, 1'b1, 1'b1);
        send(4'sd1, 14, 1'b1, 1'b1);
        send(4'sd1, 43, 1'b1, 1'b0);
        drain();
        pulse_clr();

        // clr during MAC aborts and flushes
        send(4'sd1, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        abort_cnt++;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("y_after_clr_abort", int'(y), 0);
        impulse3();

        // rst during MAC aborts and flushes
        send(4'sd1, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        abort_cnt++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("y_after_rst_abort", int'(y), 0);
        chk("in_ready_after_rst", int'(in_ready), 1);
        impulse3();

        chk("total_outputs", outs, 22);
        chk("coef_err_pulses", err_pulses, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
